mlp_layer_engine: RTL and testbench

- Parametrised, self-sequencing fully-connected layer engine; successor to the fixed 62-input / 30-hidden / 10-output MLP datapath.
- NPU parallel MAC lanes process output neurons in groups of NPU, against an internally buffered input vector.
- Weights and biases are fetched from external synchronous ROMs. Results are saturated, optionally ReLU'd, streamed out over valid/ready, and a running argmax is kept.
- Instances are chained per layer: hidden layer with ReLU, output layer with argmax.

---
 rtl/mlp_layer_engine_if.sv | 47 ++++
 rtl/mlp_layer_engine.sv | 215 +++++++++++++++++++++
 tb/tb_mlp_layer_engine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_engine_if.sv
// Bus bundle for mlp_layer_engine: x-buffer writes, layer control, weight/bias ROM port,
// result stream and argmax. The engine takes the slave side; the environment takes master.
interface mlp_layer_engine_if #(
    parameter int DW      = 8,
    parameter int NPU     = 8,
    parameter int MAX_IN  = 62,
    parameter int MAX_OUT = 30
);
    localparam int IW  = $clog2(MAX_IN + 1);
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int NG  = (MAX_OUT + NPU - 1) / NPU;
    localparam int WAW = $clog2(NG * MAX_IN);
    localparam int BAW = (NG > 1) ? $clog2(NG) : 1;

    logic               x_wr_en;
    logic [IW-1:0]      x_wr_addr;
    logic [DW-1:0]      x_wr_data;
    logic [IW-1:0]      n_in;
    logic [OW-1:0]      n_out;
    logic               relu_en;
    logic               start;
    logic               busy;
    logic               done;
    logic               w_rd;
    logic [WAW-1:0]     w_addr;
    logic [BAW-1:0]     b_addr;
    logic [NPU*DW-1:0]  w_data;
    logic [NPU*DW-1:0]  b_data;
    logic               y_valid;
    logic               y_ready;
    logic [OW-1:0]      y_idx;
    logic [DW-1:0]      y_data;
    logic [OW-1:0]      argmax_idx;
    logic [DW-1:0]      argmax_val;

    modport slave (
        input  x_wr_en, x_wr_addr, x_wr_data, n_in, n_out, relu_en, start, w_data, b_data,
               y_ready,
        output busy, done, w_rd, w_addr, b_addr, y_valid, y_idx, y_data, argmax_idx, argmax_val
    );

    modport master (
        output x_wr_en, x_wr_addr, x_wr_data, n_in, n_out, relu_en, start, w_data, b_data,
               y_ready,
        input  busy, done, w_rd, w_addr, b_addr, y_valid, y_idx, y_data, argmax_idx, argmax_val
    );
endinterface

// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: NPU MAC lanes per neuron group, ROM-fed weights/biases,
// saturating optional-ReLU results streamed over valid/ready with a running argmax.
module mlp_layer_engine #(
    parameter int DW      = 8,
    parameter int NPU     = 8,
    parameter int MAX_IN  = 62,
    parameter int MAX_OUT = 30,
    parameter int ACCW    = 24,
    parameter int SHIFT   = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mlp_layer_engine_if.slave io_bus
);
    localparam int IW  = $clog2(MAX_IN + 1);
    localparam int OW  = $clog2(MAX_OUT + 1);
    localparam int NG  = (MAX_OUT + NPU - 1) / NPU;
    localparam int WAW = $clog2(NG * MAX_IN);
    localparam int BAW = (NG > 1) ? $clog2(NG) : 1;
    localparam int XAW = $clog2(MAX_IN);
    localparam int LW  = $clog2(NPU) + 1;
    localparam int BW  = $clog2(NG * NPU + 1);
    localparam logic signed [ACCW-1:0] SatHi = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SatLo = ACCW'(-(2 ** (DW - 1)));

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StEmit, StDone} state_e;

    state_e                 r_state;
    logic [IW-1:0]          r_n_in, r_k;
    logic [OW-1:0]          r_n_out, r_y_idx, r_am_idx;
    logic                   r_relu, r_w_rd, r_dv, r_dfirst, r_busy, r_done, r_y_valid;
    logic                   r_am_valid;
    logic [BW-1:0]          r_base;
    logic [LW-1:0]          r_lane;
    logic [WAW-1:0]         r_w_addr;
    logic [BAW-1:0]         r_b_addr;
    logic signed [DW-1:0]   r_y_data, r_am_val, r_x_q;
    logic signed [ACCW-1:0] r_acc [NPU];
    logic signed [DW-1:0]   r_xbuf [MAX_IN];

    logic [IW-1:0]          w_n_in_c;
    logic [OW-1:0]          w_n_out_c;
    logic [LW-1:0]          w_nxt_lane;
    logic [BW-1:0]          w_nxt_idx;
    logic                   w_nxt_ok, w_grp_more;
    logic signed [DW-1:0]   w_nxt_data;
    logic signed [2*DW-1:0] w_prod [NPU];
    logic signed [ACCW-1:0] w_term [NPU];
    logic signed [ACCW-1:0] w_bias [NPU];
    logic signed [ACCW-1:0] w_sh [NPU];
    logic signed [DW-1:0]   w_res [NPU];

    assign w_n_in_c   = (io_bus.n_in > IW'(MAX_IN)) ? IW'(MAX_IN) : io_bus.n_in;
    assign w_n_out_c  = (io_bus.n_out > OW'(MAX_OUT)) ? OW'(MAX_OUT) : io_bus.n_out;
    assign w_nxt_lane = r_lane + 1'b1;
    assign w_nxt_idx  = r_base + BW'(w_nxt_lane);
    assign w_nxt_ok   = (w_nxt_lane < LW'(NPU)) && (w_nxt_idx < BW'(r_n_out));
    assign w_grp_more = (r_base + BW'(NPU)) < BW'(r_n_out);

    always_comb begin
        for (int j = 0; j < NPU; j++) begin
            w_prod[j] = r_x_q * $signed(io_bus.w_data[j*DW +: DW]);
            w_term[j] = {{(ACCW - 2 * DW){w_prod[j][2*DW-1]}}, w_prod[j]};
            w_bias[j] = {{(ACCW - DW){io_bus.b_data[j*DW+DW-1]}}, io_bus.b_data[j*DW +: DW]}
                        <<< SHIFT;
            w_sh[j]   = r_acc[j] >>> SHIFT;
            if (w_sh[j] > SatHi) begin
                w_res[j] = SatHi[DW-1:0];
            end else if (w_sh[j] < SatLo) begin
                w_res[j] = SatLo[DW-1:0];
            end else begin
                w_res[j] = w_sh[j][DW-1:0];
            end
            if (r_relu && w_res[j][DW-1]) w_res[j] = '0;
        end
    end

    always_comb begin
        w_nxt_data = '0;
        for (int j = 0; j < NPU; j++) begin
            if (w_nxt_lane == LW'(j)) w_nxt_data = w_res[j];
        end
    end

    // x buffer is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (io_bus.x_wr_en && !r_busy && (io_bus.x_wr_addr < IW'(MAX_IN))) begin
            r_xbuf[io_bus.x_wr_addr[XAW-1:0]] <= io_bus.x_wr_data;
        end
    end

    // ROM data lands one cycle after w_rd; r_dv/r_dfirst track that return slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < NPU; j++) r_acc[j] <= '0;
        end else if (r_dv) begin
            for (int j = 0; j < NPU; j++) begin
                r_acc[j] <= r_dfirst ? (w_bias[j] + w_term[j]) : (r_acc[j] + w_term[j]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_n_in     <= '0;
            r_n_out    <= '0;
            r_relu     <= 1'b0;
            r_k        <= '0;
            r_base     <= '0;
            r_lane     <= '0;
            r_w_addr   <= '0;
            r_b_addr   <= '0;
            r_w_rd     <= 1'b0;
            r_dv       <= 1'b0;
            r_dfirst   <= 1'b0;
            r_x_q      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_y_valid  <= 1'b0;
            r_y_idx    <= '0;
            r_y_data   <= '0;
            r_am_valid <= 1'b0;
            r_am_idx   <= '0;
            r_am_val   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_dv     <= r_w_rd;
            r_dfirst <= r_w_rd && (r_k == '0);
            r_x_q    <= r_xbuf[r_k[XAW-1:0]];
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_n_in     <= w_n_in_c;
                        r_n_out    <= w_n_out_c;
                        r_relu     <= io_bus.relu_en;
                        r_am_valid <= 1'b0;
                        if ((w_n_in_c == '0) || (w_n_out_c == '0)) begin
                            r_am_idx <= '0;
                            r_am_val <= '0;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end else begin
                            r_busy   <= 1'b1;
                            r_base   <= '0;
                            r_b_addr <= '0;
                            r_w_addr <= '0;
                            r_k      <= '0;
                            r_w_rd   <= 1'b1;
                            r_state  <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (r_k == r_n_in - 1'b1) begin
                        r_w_rd  <= 1'b0;
                        r_state <= StDrain;
                    end else begin
                        r_k      <= r_k + 1'b1;
                        r_w_addr <= r_w_addr + 1'b1;
                    end
                end
                StDrain: begin
                    r_lane  <= '0;
                    r_state <= StEmit;
                end
                StEmit: begin
                    if (!r_y_valid) begin
                        r_y_valid <= 1'b1;
                        r_y_idx   <= OW'(r_base);
                        r_y_data  <= w_res[0];
                    end else if (io_bus.y_ready) begin
                        if (!r_am_valid || (r_y_data > r_am_val)) begin
                            r_am_valid <= 1'b1;
                            r_am_idx   <= r_y_idx;
                            r_am_val   <= r_y_data;
                        end
                        if (w_nxt_ok) begin
                            r_lane   <= w_nxt_lane;
                            r_y_idx  <= OW'(w_nxt_idx);
                            r_y_data <= w_nxt_data;
                        end else if (w_grp_more) begin
                            // next group's weights follow contiguously in the ROM
                            r_y_valid <= 1'b0;
                            r_base    <= r_base + BW'(NPU);
                            r_b_addr  <= r_b_addr + 1'b1;
                            r_w_addr  <= r_w_addr + 1'b1;
                            r_k       <= '0;
                            r_w_rd    <= 1'b1;
                            r_state   <= StFetch;
                        end else begin
                            r_y_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= StDone;
                        end
                    end
                end
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.w_rd       = r_w_rd;
    assign io_bus.w_addr     = r_w_addr;
    assign io_bus.b_addr     = r_b_addr;
    assign io_bus.y_valid    = r_y_valid;
    assign io_bus.y_idx      = r_y_idx;
    assign io_bus.y_data     = r_y_data;
    assign io_bus.argmax_idx = r_am_idx;
    assign io_bus.argmax_val = r_am_val;
endmodule

// File: tb/tb_mlp_layer_engine.sv
// Bench for mlp_layer_engine: synchronous ROM model, arithmetic reference model with
// scoreboard queues, per-cycle monitor, and literal checks on the directed vectors.
module tb_mlp_layer_engine;
    localparam int DW = 8, NPU = 8, MAX_IN = 62, MAX_OUT = 30, ACCW = 24, SHIFT = 0;

    logic clk, rst_n;
    mlp_layer_engine_if #(.DW(DW), .NPU(NPU), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT)) bus ();

    mlp_layer_engine #(
        .DW(DW), .NPU(NPU), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .ACCW(ACCW), .SHIFT(SHIFT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    logic [NPU*DW-1:0] w_mem [256];
    logic [NPU*DW-1:0] b_mem [4];
    int x_tb [MAX_IN];

    int n_cmp = 0, n_err = 0;
    bit mon_en = 0, stall_en = 0, stalled = 0;
    int exp_idx[$], exp_dat[$], exp_wa[$], exp_ba[$];
    int got_idx[$], got_dat[$], got_wa[$], got_ba[$];
    int exp_am_idx, exp_am_val, done_cnt, busy_cnt;
    bit hold_pend = 0;
    int hold_idx, hold_dat;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.w_rd) begin
            bus.w_data <= w_mem[bus.w_addr];
            bus.b_data <= b_mem[bus.b_addr];
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int lane(input logic [NPU*DW-1:0] word, input int j);
        logic signed [DW-1:0] v;
        v = word[j*DW +: DW];
        return v;
    endfunction

    function automatic int got_at(input int i);
        return (i < got_dat.size()) ? got_dat[i] : -9999;
    endfunction

    task automatic set_w(input int addr, input int j, input int v);
        w_mem[addr][j*DW +: DW] = DW'(v);
    endtask

    task automatic set_b(input int addr, input int j, input int v);
        b_mem[addr][j*DW +: DW] = DW'(v);
    endtask

    task automatic write_x(input int a, input int v);
        @(posedge clk); #1;
        bus.x_wr_en = 1; bus.x_wr_addr = 6'(a); bus.x_wr_data = DW'(v);
        x_tb[a] = v;
        @(posedge clk); #1;
        bus.x_wr_en = 0;
    endtask

    // Reference: y[n] = clamp((b<<SHIFT + sum x*w) >>> SHIFT), ROM layout by group and input
    task automatic build_model(input int nin, input int nout, input bit relu);
        int acc, r, g, j;
        exp_idx.delete(); exp_dat.delete(); exp_wa.delete(); exp_ba.delete();
        exp_am_idx = 0; exp_am_val = 0;
        for (int n = 0; n < nout; n++) begin
            g = n / NPU; j = n % NPU;
            acc = lane(b_mem[g], j) * (2 ** SHIFT);
            for (int k = 0; k < nin; k++) acc += x_tb[k] * lane(w_mem[g * nin + k], j);
            r = acc >>> SHIFT;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            if (relu && r < 0) r = 0;
            exp_idx.push_back(n); exp_dat.push_back(r);
            if (n == 0 || r > exp_am_val) begin exp_am_idx = n; exp_am_val = r; end
        end
        for (int gg = 0; gg < (nout + NPU - 1) / NPU; gg++)
            for (int k = 0; k < nin; k++) begin
                exp_wa.push_back(gg * nin + k); exp_ba.push_back(gg);
            end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_valid", int'(bus.y_valid), 1);
                chk("hold_idx", int'(bus.y_idx), hold_idx);
                chk("hold_data", int'($signed(bus.y_data)), hold_dat);
            end
            hold_pend = bus.y_valid && !bus.y_ready;
            hold_idx  = int'(bus.y_idx);
            hold_dat  = int'($signed(bus.y_data));
            if (bus.w_rd) begin
                got_wa.push_back(int'(bus.w_addr)); got_ba.push_back(int'(bus.b_addr));
                if (exp_wa.size() == 0) chk("w_rd_extra", 1, 0);
                else begin
                    chk("w_addr", int'(bus.w_addr), exp_wa.pop_front());
                    chk("b_addr", int'(bus.b_addr), exp_ba.pop_front());
                end
            end
            if (bus.y_valid && bus.y_ready) begin
                got_idx.push_back(int'(bus.y_idx)); got_dat.push_back(int'($signed(bus.y_data)));
                if (exp_idx.size() == 0) chk("y_extra", 1, 0);
                else begin
                    chk("y_idx", int'(bus.y_idx), exp_idx.pop_front());
                    chk("y_data", int'($signed(bus.y_data)), exp_dat.pop_front());
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("busy_at_done", int'(bus.busy), 0);
            end
            if (bus.busy) busy_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en && !stalled && bus.y_valid && bus.y_idx == 1) begin
                bus.y_ready = 0;
                stalled = 1;
                repeat (5) @(posedge clk);
                #1 bus.y_ready = 1;
            end
        end
    end

    task automatic run_layer(input int nin, input int nout, input bit relu, input bit disturb);
        int c;
        build_model(nin, nout, relu);
        got_idx.delete(); got_dat.delete(); got_wa.delete(); got_ba.delete();
        done_cnt = 0; busy_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1; bus.n_in = 6'(nin); bus.n_out = 5'(nout); bus.relu_en = relu;
        @(posedge clk); #1;
        bus.start = 0;
        if (disturb) begin
            repeat (2) @(posedge clk); #1;
            bus.start = 1; bus.n_in = 6'd1;
            bus.x_wr_en = 1; bus.x_wr_addr = 6'd3; bus.x_wr_data = -8'sd77;
            @(posedge clk); #1;
            bus.start = 0; bus.x_wr_en = 0;
        end
        c = 0;
        do begin @(negedge clk); c++; end while (!bus.done && c < 3000);
        chk("done_seen", int'(bus.done), 1);
        @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("y_missing", exp_idx.size(), 0);
        chk("w_missing", exp_wa.size(), 0);
        chk("argmax_idx", int'(bus.argmax_idx), exp_am_idx);
        chk("argmax_val", int'($signed(bus.argmax_val)), exp_am_val);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_w_rd"}, int'(bus.w_rd), 0);
        chk({tag, "_y_valid"}, int'(bus.y_valid), 0);
        chk({tag, "_w_addr"}, int'(bus.w_addr), 0);
        chk({tag, "_b_addr"}, int'(bus.b_addr), 0);
        chk({tag, "_y_idx"}, int'(bus.y_idx), 0);
        chk({tag, "_y_data"}, int'(bus.y_data), 0);
        chk({tag, "_am_idx"}, int'(bus.argmax_idx), 0);
        chk({tag, "_am_val"}, int'(bus.argmax_val), 0);
    endtask

    initial begin
        int dcnt;
        rst_n = 0;
        bus.x_wr_en = 0; bus.x_wr_addr = '0; bus.x_wr_data = '0; bus.n_in = '0;
        bus.n_out = '0; bus.relu_en = 0; bus.start = 0; bus.y_ready = 1;
        bus.w_data = '0; bus.b_data = '0;
        for (int i = 0; i < 256; i++) w_mem[i] = '0;
        for (int i = 0; i < 4; i++) b_mem[i] = '0;
        for (int i = 0; i < MAX_IN; i++) x_tb[i] = 0;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        mon_en = 1;

        // Small layer: lane0 = sum+4, lane1 = -sum
        for (int k = 0; k < 3; k++) begin
            write_x(k, k + 1); set_w(k, 0, 1); set_w(k, 1, -1);
        end
        set_b(0, 0, 4); set_b(0, 1, 0);
        run_layer(3, 2, 0, 0);
        chk("t1_y0", got_at(0), 10);
        chk("t1_y1", got_at(1), -6);
        chk("t1_am_idx", int'(bus.argmax_idx), 0);
        chk("t1_am_val", int'($signed(bus.argmax_val)), 10);
        chk("t1_waddr_last", (got_wa.size() == 3) ? got_wa[2] : -1, 2);

        run_layer(3, 2, 1, 0);
        chk("t2_y0", got_at(0), 10);
        chk("t2_y1_relu", got_at(1), 0);
        chk("t2_am_val", int'($signed(bus.argmax_val)), 10);

        // Saturation both ways
        write_x(0, 127); write_x(1, 127);
        for (int k = 0; k < 2; k++) begin set_w(k, 0, 127); set_w(k, 1, -128); end
        set_b(0, 0, 0);
        run_layer(2, 2, 0, 0);
        chk("t3_sat_hi", got_at(0), 127);
        chk("t3_sat_lo", got_at(1), -128);

        // Two groups; a start and an x write during busy must both be ignored
        write_x(0, 3); write_x(1, -2); write_x(2, 5); write_x(3, 1);
        for (int a = 0; a < 8; a++)
            for (int j = 0; j < NPU; j++) set_w(a, j, ((a * 3 + j * 5) % 17) - 8);
        for (int j = 0; j < NPU; j++) begin set_b(0, j, j - 3); set_b(1, j, j + 2); end
        run_layer(4, 10, 0, 1);
        chk("t4_busy_cycles", busy_cnt, 22);
        chk("t4_waddr4", (got_wa.size() > 4) ? got_wa[4] : -1, 4);
        chk("t4_baddr4", (got_ba.size() > 4) ? got_ba[4] : -1, 1);
        chk("t4_last_idx", (got_idx.size() == 10) ? got_idx[9] : -1, 9);

        // Stall on idx 1; tie at neurons 3 and 7
        write_x(0, 1);
        begin
            int wv[10] = '{10, 20, -5, 50, 7, 30, 0, 50, 40, -3};
            for (int n = 0; n < 8; n++) set_w(0, n, wv[n]);
            set_w(1, 0, wv[8]); set_w(1, 1, wv[9]);
        end
        b_mem[0] = '0; b_mem[1] = '0;
        stall_en = 1;
        run_layer(1, 10, 0, 0);
        stall_en = 0;
        chk("t5_stalled", int'(stalled), 1);
        chk("t5_am_idx", int'(bus.argmax_idx), 3);
        chk("t5_am_val", int'($signed(bus.argmax_val)), 50);
        chk("t5_count", got_idx.size(), 10);

        // Zero-length layer
        @(posedge clk); #1;
        bus.start = 1; bus.n_in = '0; bus.n_out = 5'd5;
        @(posedge clk); #1;
        bus.start = 0;
        @(negedge clk);
        chk("t6_done", int'(bus.done), 1);
        chk("t6_y_valid", int'(bus.y_valid), 0);
        chk("t6_am_idx", int'(bus.argmax_idx), 0);
        chk("t6_am_val", int'(bus.argmax_val), 0);
        @(negedge clk);
        chk("t6_done_once", int'(bus.done), 0);

        // Reset during fetch
        mon_en = 0;
        write_x(0, 9);
        @(posedge clk); #1;
        bus.start = 1; bus.n_in = 6'd4; bus.n_out = 5'd10;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        chk("t7_in_fetch", int'(bus.w_rd), 1);
        rst_n = 0;
        #1 check_zero("t7_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        dcnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        chk("t7_quiet_after_rst", dcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
